// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-number source.
// Tap masks follow the left-shift convention: bit i set feeds s[i] into the new s[0].
package lfsr_pkg;

    typedef enum logic {
        StFill,
        StValid
    } fill_state_e;

    // Maximal-length feedback masks for widths 3..32; other widths return 0.
    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Callers zero-extend s and truncate the result to their own width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
        return {s[30:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and all-zero lock-up repair.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_next,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] SeedInit = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] s_q;
    logic             lockup_q;
    logic             zero;

    assign zero       = (s_q == '0);
    assign state_next = WIDTH'(lfsr_next(32'(s_q), 32'(TAPS)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q      <= SeedInit;
            lockup_q <= 1'b0;
        end else begin
            // A seed load overrides the repair, so no pulse is raised in that case.
            lockup_q <= !seed_load && zero;
            if (seed_load) begin
                s_q <= (seed_in == '0) ? WIDTH'(1) : seed_in;
            end else if (zero) begin
                s_q <= WIDTH'(1);
            end else if (enable) begin
                s_q <= state_next;
            end
        end
    end

    assign state  = s_q;
    assign lockup = lockup_q;

endmodule

// File: rtl/lfsr_rng.sv
// Range-limited random-number source: gathers OUT_W LFSR steps per candidate and
// rejects candidates >= RANGE, delivering accepted values over valid/ready.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8805),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      OUT_W = 3,
    parameter int unsigned      RANGE = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out,
    output logic             lockup
);

    localparam int unsigned    CntW    = $clog2(OUT_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OUT_W - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [OUT_W-1:0] candidate;
    logic             accept;
    logic             last;
    logic             zero;
    logic [CntW-1:0]  cnt_base;

    fill_state_e      st_q;
    logic [CntW-1:0]  cnt_q;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .state      (state),
        .state_next (state_next),
        .lockup     (lockup)
    );

    always_comb begin
        candidate = OUT_W'(state_next);
        accept    = 32'(candidate) < RANGE;
        zero      = (state == '0);
        // On a handshake edge the step taken counts as the first fill step.
        cnt_base  = (st_q == StValid) ? '0 : cnt_q;
        last      = (cnt_base == CntLast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= StFill;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (seed_load || zero) begin
            st_q        <= StFill;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (st_q == StFill || out_ready) begin
            st_q        <= StFill;
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_base;
            if (enable) begin
                if (last) begin
                    cnt_q <= '0;
                    if (accept) begin
                        out_q       <= candidate;
                        out_valid_q <= 1'b1;
                        st_q        <= StValid;
                    end
                end else begin
                    cnt_q <= cnt_base + CntW'(1);
                end
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed scoreboard bench for lfsr_rng with WIDTH=4, TAPS=4'h9, OUT_W=2, RANGE=3.
module tb_lfsr_rng;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned OUT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out;
    logic             lockup;
    logic [WIDTH-1:0] s;

    int checks = 0;
    int errors = 0;
    logic [OUT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_rng #(
        .WIDTH (WIDTH),
        .TAPS  (4'h9),
        .SEED  (4'h1),
        .OUT_W (OUT_W),
        .RANGE (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out       (out),
        .lockup    (lockup)
    );

    assign s = dut.u_core.s_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
    endtask

    // Monitor: every handshake consumes one expected value.
    initial begin
        logic [OUT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d, expected no output", out);
                end else begin
                    e = exp_q.pop_front();
                    check("out_value", 32'(out), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [3:0] s_tab [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                   4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
        logic       v_tab [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] bp_tab [10] = '{4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2,
                                    4'h4, 4'h8};

        enable    = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #2;
        check("reset_s", 32'(s), 32'h1);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_out", 32'(out), 32'h0);
        check("reset_lockup", 32'(lockup), 32'h0);
        reset = 1'b0;

        // Full period with continuous ready; rejects at edges 2 and 8.
        enable    = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("period_s", 32'(s), 32'(s_tab[i]));
            check("period_valid", 32'(out_valid), 32'(v_tab[i]));
        end
        enable    = 1'b0;
        out_ready = 1'b0;

        // Backpressure: value held while the LFSR keeps stepping.
        do_reset();
        enable = 1'b1;
        repeat (4) tick();
        check("bp_rise_valid", 32'(out_valid), 32'h1);
        check("bp_rise_out", 32'(out), 32'h2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_s", 32'(s), 32'(bp_tab[i]));
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            check("bp_hold_out", 32'(out), 32'h2);
        end
        exp_q.push_back(2'd2);
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'h0);
        check("bp_release_s", 32'(s), 32'h1);
        out_ready = 1'b0;
        enable    = 1'b0;

        // Seed load while VALID, with enable also high.
        do_reset();
        enable = 1'b1;
        repeat (4) tick();
        check("seed_pre_valid", 32'(out_valid), 32'h1);
        seed_load = 1'b1;
        seed_in   = 4'b1000;
        tick();
        check("seed_s", 32'(s), 32'h8);
        check("seed_valid", 32'(out_valid), 32'h0);
        seed_load = 1'b0;
        tick();
        check("seed_step1_s", 32'(s), 32'h1);
        tick();
        check("seed_reject_s", 32'(s), 32'h3);
        check("seed_reject_valid", 32'(out_valid), 32'h0);
        repeat (2) tick();
        check("seed_reject2_s", 32'(s), 32'hF);
        check("seed_reject2_valid", 32'(out_valid), 32'h0);
        repeat (2) tick();
        check("seed_accept_valid", 32'(out_valid), 32'h1);
        check("seed_accept_out", 32'(out), 32'h1);
        enable = 1'b0;

        // Zero seed and lock-up repair.
        seed_load = 1'b1;
        seed_in   = 4'b0000;
        tick();
        check("zseed_s", 32'(s), 32'h1);
        check("zseed_lockup", 32'(lockup), 32'h0);
        check("zseed_valid", 32'(out_valid), 32'h0);
        seed_load = 1'b0;
        force dut.u_core.s_q = 4'b0000;
        #1;
        release dut.u_core.s_q;
        tick();
        check("lockup_s", 32'(s), 32'h1);
        check("lockup_pulse", 32'(lockup), 32'h1);
        check("lockup_valid", 32'(out_valid), 32'h0);
        tick();
        check("lockup_end", 32'(lockup), 32'h0);
        check("lockup_hold_s", 32'(s), 32'h1);

        // Asynchronous reset between edges while VALID.
        do_reset();
        enable = 1'b1;
        repeat (4) tick();
        check("areset_pre_valid", 32'(out_valid), 32'h1);
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(out_valid), 32'h0);
        check("areset_s", 32'(s), 32'h1);
        check("areset_out", 32'(out), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("freeze_s", 32'(s), 32'h1);
        end

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
